// File: rtl/pool_rd_arb_pkg.sv
// pool_rd_arb_pkg: arbiter state type, default bus widths and a constant clog2.
package pool_rd_arb_pkg;
  typedef enum logic [0:0] {IDLE, ISSUE} arb_state_e;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_ID_W = 4;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_DATA_W = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pool_rd_arb_rr_pick.sv
// rr_pick: chooses the next eligible requester, round-robin from ptr_i.
// With POOL_RD_ARB_FIXED_PRIO_EN defined the lowest eligible index wins instead.
import pool_rd_arb_pkg::*;
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDXW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic [IDXW-1:0]    gnt_o,
  output logic               vld_o
);
  assign vld_o = |elig_i;
`ifdef POOL_RD_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  always_comb begin
    gnt_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (elig_i[k]) gnt_o = IDXW'(k);
  end
`else
  logic [IDXW-1:0] j;
  // scanning backwards lets the candidate nearest the pointer overwrite the rest
  always_comb begin
    gnt_o = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDXW'((int'(ptr_i) + k) % NUM_REQ);
      if (elig_i[j]) gnt_o = j;
    end
  end
`endif
endmodule

// File: rtl/pool_rd_arb.sv
// pool_rd_arb: shares one bus read port among NUM_REQ masters with ID tagging, R routing and outstanding caps.
// Define POOL_RD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
import pool_rd_arb_pkg::*;
module pool_rd_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ID_W = DEF_ID_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        Req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] Req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]  Req_arlen,
  input  logic [NUM_REQ*ID_W-1:0]   Req_arid,
  output logic [NUM_REQ-1:0]        Req_arready,
  output logic [NUM_REQ-1:0]        Req_rvalid,
  output logic [NUM_REQ-1:0]        Req_rlast,
  output logic [ID_W-1:0]           Req_rid,
  output logic [DATA_W-1:0]         Req_rdata,
  output logic                      ArbBus_arvalid,
  output logic [ADDR_W-1:0]         ArbBus_araddr,
  output logic [LEN_W-1:0]          ArbBus_arlen,
  output logic [ID_W-1:0]           ArbBus_arid,
  input  logic                      BusArb_arready,
  input  logic                      BusArb_rvalid,
  input  logic                      BusArb_rlast,
  input  logic [ID_W-1:0]           BusArb_rid,
  input  logic [DATA_W-1:0]         BusArb_rdata,
  output logic                      Arb_err
);
  localparam int IDXW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_OUTST + 1);
  arb_state_e state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx, r_idx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [NUM_REQ-1:0][CW-1:0] outst_q, outst_d;
  logic [NUM_REQ-1:0] elig, inc, dec;
  logic pick_vld, ar_hs, r_ok, err_q, err_d;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) elig[i] = Req_arvalid[i] && (outst_q[i] < CW'(MAX_OUTST));
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_pick (
    .elig_i(elig),
    .ptr_i (ptr_q),
    .gnt_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign ArbBus_arvalid = state_q == ISSUE;
  assign ArbBus_araddr = addr_q;
  assign ArbBus_arlen = len_q;
  assign ArbBus_arid = id_q;
  assign ar_hs = ArbBus_arvalid && BusArb_arready;
  assign inc = ar_hs ? NUM_REQ'(1) << grant_q : '0;
  assign Req_arready = inc;

  assign r_idx = BusArb_rid[ID_W-1 -: IDXW];
  assign r_ok = int'(r_idx) < NUM_REQ;
  assign Req_rvalid = (BusArb_rvalid && r_ok) ? NUM_REQ'(1) << r_idx : '0;
  assign Req_rlast = BusArb_rlast ? Req_rvalid : '0;
  assign Req_rid = {{IDXW{1'b0}}, BusArb_rid[ID_W-IDXW-1:0]};
  assign Req_rdata = BusArb_rdata;
  assign dec = Req_rlast;
  assign Arb_err = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    len_d = len_q;
    id_d = id_q;
    if (state_q == IDLE && pick_vld) begin
      state_d = ISSUE;
      grant_d = pick_idx;
      addr_d = Req_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
      len_d = Req_arlen[int'(pick_idx)*LEN_W +: LEN_W];
      id_d = {pick_idx, Req_arid[int'(pick_idx)*ID_W +: ID_W-IDXW]};
    end else if (ar_hs) begin
      state_d = IDLE;
      ptr_d = (grant_q == IDXW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  // a same-cycle issue and completion cancel; counters saturate at both ends
  always_comb begin
    outst_d = outst_q;
    err_d = err_q || (BusArb_rvalid && !r_ok);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (dec[i] && !inc[i]) begin
        if (outst_q[i] == '0) err_d = 1'b1;
        else outst_d[i] = outst_q[i] - 1'b1;
      end else if (inc[i] && !dec[i] && outst_q[i] != CW'(MAX_OUTST)) begin
        outst_d[i] = outst_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      id_q <= '0;
      outst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      len_q <= len_d;
      id_q <= id_d;
      outst_q <= outst_d;
      err_q <= err_d;
    end
  end
endmodule
